parse_ntt: RTL and testbench

PARSE_NTT -- requirements
Module: parse_ntt

---
 rtl/parse_ntt.sv | 119 +++++++++++
 tb/tb_parse_ntt.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/parse_ntt.sv
// parse_ntt: rejection-samples a 12-bit polynomial from a captured XOF byte
// stream. One byte triple (two 12-bit candidates) is consumed per cycle;
// candidates below Q are packed into A in stream order.
//
// Handshake: active is a level start request. In IDLE a high active captures B
// and starts a run; finish is high for as long as the FSM sits in DONE, and
// DONE is left only once active has been seen low, so a requester that keeps
// active high never triggers an unintended restart.
//
// dbg_state exposes the FSM: 0 = IDLE, 1 = RUN, 2 = DONE.
module parse_ntt #(
  parameter int Q      = 3329,
  parameter int N_COEF = 256,
  parameter int B_SIZE = 3072
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  active,
  input  logic [0:B_SIZE-1]     B,
  output logic                  finish,
  output logic [0:N_COEF*12-1]  A,
  output logic [8:0]            count,
  output logic                  short,
  output logic [1:0]            dbg_state
);

  localparam int             N_TRIPLES = B_SIZE / 24;
  localparam int             TW        = $clog2(N_TRIPLES);
  localparam logic [TW-1:0]  T_LAST    = TW'(N_TRIPLES - 1);
  localparam logic [11:0]    Q_L       = 12'(Q);
  localparam logic [8:0]     N_L       = 9'(N_COEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [0:B_SIZE-1]    b_q, b_d;
  logic [0:N_COEF*12-1] a_q, a_d;
  logic [8:0]           count_q, count_d;
  logic [TW-1:0]        t_q, t_d;

  // Current triple, taken from the captured copy of the stream only.
  logic [7:0]  b0, b1, b2;
  logic [11:0] d1, d2;
  logic        wr1, wr2;
  logic [8:0]  cnt1, cnt2;

  assign b0 = b_q[24*int'(t_q)      +: 8];
  assign b1 = b_q[24*int'(t_q) + 8  +: 8];
  assign b2 = b_q[24*int'(t_q) + 16 +: 8];

  // d1 takes b1's low nibble as its top bits, d2 takes b1's high nibble as its low bits.
  assign d1 = {b1[3:0], b0};
  assign d2 = {b2, b1[7:4]};

  // d1 has precedence; d2 lands in the slot after d1 when both are accepted.
  assign wr1  = (d1 < Q_L) && (count_q < N_L);
  assign cnt1 = count_q + 9'(wr1);
  assign wr2  = (d2 < Q_L) && (cnt1 < N_L);
  assign cnt2 = cnt1 + 9'(wr2);

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    a_d     = a_q;
    count_d = count_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = RUN;
          b_d     = B;
          a_d     = '0;
          count_d = '0;
          t_d     = '0;
        end
      end
      RUN: begin
        if (wr1) a_d[12*int'(count_q) +: 12] = d1;
        if (wr2) a_d[12*int'(cnt1) +: 12]    = d2;
        count_d = cnt2;
        t_d     = t_q + TW'(1);
        if ((t_q == T_LAST) || (cnt2 == N_L)) state_d = DONE;
      end
      DONE: begin
        if (!active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset clearing every piece of run state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      a_q     <= '0;
      count_q <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      a_q     <= a_d;
      count_q <= count_d;
      t_q     <= t_d;
    end
  end

  assign finish    = (state_q == DONE);
  assign A         = a_q;
  assign count     = count_q;
  assign short     = (state_q == DONE) && (count_q < N_L);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_parse_ntt.sv
// Directed/randomized bench for parse_ntt with a queue-based sampling model.
module tb_parse_ntt;

  localparam int Q  = 3329;
  localparam int N  = 256;
  localparam int BS = 3072;
  localparam int NB = 384;

  logic            clk = 1'b0;
  logic            rst;
  logic            active;
  logic [0:BS-1]   B;
  logic            finish;
  logic [0:N*12-1] A;
  logic [8:0]      count;
  logic            short;
  logic [1:0]      dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  by [NB];
  logic [11:0] exp_q[$];

  parse_ntt #(.Q(Q), .N_COEF(N), .B_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .active(active), .B(B),
    .finish(finish), .A(A), .count(count), .short(short),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic load_b();
    for (int i = 0; i < NB; i++) B[8*i +: 8] = by[i];
  endtask

  // Reference: walk the byte triples and keep every candidate below Q, up to N.
  task automatic build_model();
    exp_q.delete();
    for (int t = 0; t < NB / 3; t++) begin
      int v0, v1, v2, c1, c2;
      v0 = int'(by[3*t]);
      v1 = int'(by[3*t+1]);
      v2 = int'(by[3*t+2]);
      c1 = v0 + 256 * (v1 % 16);
      c2 = (v1 / 16) + 16 * v2;
      if (c1 < Q && exp_q.size() < N) exp_q.push_back(12'(c1));
      if (c2 < Q && exp_q.size() < N) exp_q.push_back(12'(c2));
    end
  endtask

  task automatic fill_triple(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
    for (int t = 0; t < NB / 3; t++) begin
      by[3*t] = x0; by[3*t+1] = x1; by[3*t+2] = x2;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++) by[i] = 8'($urandom_range(0, 255));
  endtask

  // All candidates forced below Q so the polynomial fills exactly on the last triple.
  task automatic fill_small();
    for (int t = 0; t < NB / 3; t++) begin
      int c1, c2;
      c1 = $urandom_range(0, Q - 1);
      c2 = $urandom_range(0, Q - 1);
      by[3*t]   = 8'(c1 % 256);
      by[3*t+1] = 8'((c1 / 256) + 16 * (c2 % 16));
      by[3*t+2] = 8'(c2 / 16);
    end
  endtask

  // Candidates clustered around the rejection bound.
  task automatic fill_boundary();
    for (int t = 0; t < NB / 3; t++) begin
      int c1, c2;
      c1 = $urandom_range(Q - 6, Q + 6);
      c2 = $urandom_range(Q - 6, Q + 6);
      by[3*t]   = 8'(c1 % 256);
      by[3*t+1] = 8'((c1 / 256) + 16 * (c2 % 16));
      by[3*t+2] = 8'(c2 / 16);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_short"}, 32'(short), 32'(exp_q.size() < N));
    for (int k = 0; k < N; k++) begin
      logic [11:0] e;
      e = (k < exp_q.size()) ? exp_q[k] : 12'd0;
      check($sformatf("%s_coef%0d", tag, k), 32'(A[12*k +: 12]), 32'(e));
    end
  endtask

  // Full run: start, latency check, result check, optional DONE hold, release.
  task automatic run_case(input string tag, input bit scramble, input int hold);
    load_b();
    build_model();
    @(negedge clk);
    active = 1'b1;
    @(posedge clk); #1;
    check({tag, "_state_run"}, 32'(dbg_state), 32'd1);
    check({tag, "_short_run"}, 32'(short), 32'd0);
    for (int i = 1; i < 128; i++) begin
      @(posedge clk); #1;
      if (scramble && i == 50)
        for (int j = 0; j < BS / 32; j++) B[32*j +: 32] = $urandom;
    end
    check({tag, "_finish_early"}, 32'(finish), 32'd0);
    @(posedge clk); #1;
    check({tag, "_finish"}, 32'(finish), 32'd1);
    check({tag, "_state_done"}, 32'(dbg_state), 32'd2);
    check_results(tag);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check({tag, "_finish_hold"}, 32'(finish), 32'd1);
      check_results({tag, "_hold"});
    end
    active = 1'b0;
    @(posedge clk); #1;
    check({tag, "_finish_idle"}, 32'(finish), 32'd0);
    check({tag, "_short_idle"}, 32'(short), 32'd0);
    check({tag, "_state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    // Reset with active high: reset must win.
    rst    = 1'b1;
    active = 1'b1;
    B      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_short", 32'(short), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_a_zero", 32'(A === '0), 32'd1);
    @(negedge clk);
    rst    = 1'b0;
    active = 1'b0;

    fill_triple(8'h00, 8'h00, 8'h00); run_case("zeros", 1'b0, 0);
    fill_triple(8'hFF, 8'hFF, 8'hFF); run_case("ones", 1'b0, 0);
    fill_triple(8'h00, 8'h0D, 8'hD0); run_case("all3328", 1'b0, 0);
    fill_triple(8'h01, 8'h0D, 8'hD0); run_case("half", 1'b0, 0);
    fill_random();   run_case("rand0", 1'b0, 0);
    fill_random();   run_case("rand_scr_hold", 1'b1, 4);
    fill_random();   run_case("rand_after_hold", 1'b0, 0);
    fill_small();    run_case("small", 1'b0, 0);
    fill_boundary(); run_case("bound", 1'b0, 2);

    // Reset in the middle of a run.
    fill_random();
    load_b();
    @(negedge clk);
    active = 1'b1;
    @(posedge clk);
    repeat (60) @(posedge clk);
    #1;
    rst    = 1'b1;
    active = 1'b0;
    @(posedge clk); #1;
    check("midrst_finish", 32'(finish), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_a_zero", 32'(A === '0), 32'd1);
    rst = 1'b0;
    fill_random(); run_case("after_rst", 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
